// File: rtl/fb_write_arbiter_if.sv
// Frame-buffer write arbiter bus: requester handshake, clear control and the
// registered write port. The oob_error signal exists only when
// FB_WRITE_BOUNDS_CHECK_EN is defined.
interface fb_write_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 12
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          clear_start;
  logic [DATA_WIDTH-1:0]         clear_color;
  logic                          clear_busy;
  logic                          clear_done;
  logic                          write_en;
  logic [ADDR_WIDTH-1:0]         write_addr;
  logic [DATA_WIDTH-1:0]         write_data;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
  logic                          oob_error;

  modport slave (
    input  req_valid, req_addr, req_data, clear_start, clear_color,
    output req_ready, clear_busy, clear_done, write_en, write_addr, write_data,
    output oob_error
  );

  modport master (
    output req_valid, req_addr, req_data, clear_start, clear_color,
    input  req_ready, clear_busy, clear_done, write_en, write_addr, write_data,
    input  oob_error
  );
`else
  modport slave (
    input  req_valid, req_addr, req_data, clear_start, clear_color,
    output req_ready, clear_busy, clear_done, write_en, write_addr, write_data
  );

  modport master (
    output req_valid, req_addr, req_data, clear_start, clear_color,
    input  req_ready, clear_busy, clear_done, write_en, write_addr, write_data
  );
`endif
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the single frame-buffer write port between
// NUM_REQ pixel writers, plus a clear sequencer that fills the whole buffer
// with one colour. Write port outputs are registered (1-cycle latency).
// Optional feature macro: FB_WRITE_BOUNDS_CHECK_EN (drops out-of-range
// writes and raises a sticky oob_error).
module fb_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 19200
) (
  input  logic              clk,
  input  logic              reset,
  fb_write_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t                  state_r, state_s;
  logic [PTR_W-1:0]        rr_ptr_r, rr_ptr_s;
  logic [ADDR_WIDTH-1:0]   cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0]   color_r, color_s;
  logic                    write_en_r, write_en_s;
  logic [ADDR_WIDTH-1:0]   write_addr_r, write_addr_s;
  logic [DATA_WIDTH-1:0]   write_data_r, write_data_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;

  logic [NUM_REQ-1:0]      grant_s;
  logic [PTR_W-1:0]        next_ptr_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic                    found_s;
  int                      scan_idx_s;
  logic                    transfer_s;

`ifdef FB_WRITE_BOUNDS_CHECK_EN
  logic                    oob_r, oob_s;
  logic                    sel_oob_s;
`endif

  // Scan requesters from the round-robin pointer upward and pick the first valid one.
  always_comb begin
    grant_s    = '0;
    next_ptr_s = rr_ptr_r;
    sel_addr_s = '0;
    sel_data_s = '0;
    found_s    = 1'b0;
    scan_idx_s = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!found_s && bus.req_valid[scan_idx_s]) begin
        found_s             = 1'b1;
        grant_s[scan_idx_s] = 1'b1;
        next_ptr_s          = PTR_W'((scan_idx_s + 1) % NUM_REQ);
        sel_addr_s          = bus.req_addr[scan_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_s          = bus.req_data[scan_idx_s*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grants only in ARB and never in the cycle a clear is requested.
  assign bus.req_ready = (state_r == ST_ARB && !bus.clear_start) ? grant_s : '0;
  assign transfer_s    = |bus.req_ready;

`ifdef FB_WRITE_BOUNDS_CHECK_EN
  assign sel_oob_s     = ({1'b0, sel_addr_s} >= (ADDR_WIDTH+1)'(DEPTH));
  assign bus.oob_error = oob_r;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ARB;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: enter CLEAR on request, leave once the last address is written.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_ARB: begin
        if (bus.clear_start) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_ARB;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_s = ST_ARB;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      default: state_s = ST_ARB;
    endcase
  end

  // Next values of the write port, clear sequencer and arbitration pointer.
  always_comb begin
    write_en_s   = 1'b0;
    write_addr_s = write_addr_r;
    write_data_s = write_data_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    cnt_s        = cnt_r;
    color_s      = color_r;
    rr_ptr_s     = rr_ptr_r;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
    oob_s        = oob_r;
`endif
    case (state_r)
      ST_ARB: begin
        if (bus.clear_start) begin
          // First clear write goes out together with clear_busy rising.
          write_en_s   = 1'b1;
          write_addr_s = '0;
          write_data_s = bus.clear_color;
          color_s      = bus.clear_color;
          cnt_s        = '0;
          busy_s       = 1'b1;
          done_s       = (LAST_ADDR == '0);
        end else if (transfer_s) begin
          rr_ptr_s     = next_ptr_s;
          busy_s       = 1'b0;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
          if (sel_oob_s) begin
            write_en_s = 1'b0;
            oob_s      = 1'b1;
          end else begin
            write_en_s   = 1'b1;
            write_addr_s = sel_addr_s;
            write_data_s = sel_data_s;
          end
`else
          write_en_s   = 1'b1;
          write_addr_s = sel_addr_s;
          write_data_s = sel_data_s;
`endif
        end else begin
          write_en_s = 1'b0;
          busy_s     = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          // Last address is on the port this cycle; release it next cycle.
          write_en_s = 1'b0;
          busy_s     = 1'b0;
          done_s     = 1'b0;
        end else begin
          cnt_s        = cnt_r + ADDR_WIDTH'(1);
          write_en_s   = 1'b1;
          write_addr_s = cnt_r + ADDR_WIDTH'(1);
          write_data_s = color_r;
          busy_s       = 1'b1;
          done_s       = ((cnt_r + ADDR_WIDTH'(1)) == LAST_ADDR);
        end
      end
      default: begin
        write_en_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset aborts any clear in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r     <= '0;
      cnt_r        <= '0;
      color_r      <= '0;
      write_en_r   <= 1'b0;
      write_addr_r <= '0;
      write_data_r <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
      oob_r        <= 1'b0;
`endif
    end else begin
      rr_ptr_r     <= rr_ptr_s;
      cnt_r        <= cnt_s;
      color_r      <= color_s;
      write_en_r   <= write_en_s;
      write_addr_r <= write_addr_s;
      write_data_r <= write_data_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
`ifdef FB_WRITE_BOUNDS_CHECK_EN
      oob_r        <= oob_s;
`endif
    end
  end

  assign bus.write_en   = write_en_r;
  assign bus.write_addr = write_addr_r;
  assign bus.write_data = write_data_r;
  assign bus.clear_busy = busy_r;
  assign bus.clear_done = done_r;

endmodule
